// File: rtl/lc3b_mem_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lc3b_mem_arbiter_pkg : shared types for the LC-3b memory port arbiter
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
package lc3b_mem_arbiter_pkg;

  localparam int unsigned LC3B_WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } lc3b_arb_state;

  typedef struct packed {
    logic                   read;
    logic                   write;
    logic [1:0]             wmask;
    logic [LC3B_WORD_W-1:0] address;
    logic [LC3B_WORD_W-1:0] wdata;
  } lc3b_mem_req;

  localparam lc3b_mem_req MEM_REQ_IDLE = '0;

  function automatic logic req_active(input lc3b_mem_req r);
    return r.read | r.write;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lc3b_mem_arbiter_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lc3b_arb_fsm : grant state machine; owns state, last_grant and grant/busy
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module lc3b_arb_fsm
  import lc3b_mem_arbiter_pkg::*;
#(
  parameter int RR_MODE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          mem_resp,
  output lc3b_arb_state state,
  output logic [1:0]    grant,
  output logic          busy
);

  localparam bit RR = (RR_MODE != 0);

  lc3b_arb_state state_q, state_d;
  logic          last_b_q, last_b_d;
  logic [1:0]    grant_q, grant_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    unique case (state_q)
      IDLE: begin
        // On a tie, round-robin hands the port to whoever did not own it last.
        if (req_a && req_b)  state_d = (RR && last_b_q) ? SERVE_A : SERVE_B;
        else if (req_a)      state_d = SERVE_A;
        else if (req_b)      state_d = SERVE_B;
      end
      SERVE_A: begin
        if (mem_resp) begin
          state_d  = IDLE;
          last_b_d = 1'b0;
        end
      end
      SERVE_B: begin
        if (mem_resp) begin
          state_d  = IDLE;
          last_b_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    grant_d = (state_d == SERVE_A) ? 2'b01 :
              (state_d == SERVE_B) ? 2'b10 : 2'b00;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_b_q <= 1'b0;
      grant_q  <= 2'b00;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
    end
  end

  assign state = state_q;
  assign grant = grant_q;
  assign busy  = busy_q;

endmodule
`default_nettype wire

// File: rtl/lc3b_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lc3b_mem_arbiter : shares the LC-3b memory port between fetch (A) and data (B)
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module lc3b_mem_arbiter
  import lc3b_mem_arbiter_pkg::*;
#(
  parameter int RR_MODE = 1,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [1:0]        a_wmask,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [15:0]       a_wdata,
  output logic              a_resp,
  output logic [15:0]       a_rdata,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [1:0]        b_wmask,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [15:0]       b_wdata,
  output logic              b_resp,
  output logic [15:0]       b_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_byte_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [15:0]       mem_wdata,
  input  logic              mem_resp,
  input  logic [15:0]       mem_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  lc3b_mem_req   req_a_s, req_b_s, mem_req_s;
  lc3b_arb_state sel;

  assign req_a_s = '{read: a_read, write: a_write, wmask: a_wmask,
                     address: a_address, wdata: a_wdata};
  assign req_b_s = '{read: b_read, write: b_write, wmask: b_wmask,
                     address: b_address, wdata: b_wdata};

  lc3b_arb_fsm #(
    .RR_MODE (RR_MODE)
  ) u_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_a    (req_active(req_a_s)),
    .req_b    (req_active(req_b_s)),
    .mem_resp (mem_resp),
    .state    (sel),
    .grant    (grant),
    .busy     (busy)
  );

  // Controls are forwarded live, so a client dropping its request mid-grant
  // simply shows up as zeros on the memory side.
  always_comb begin
    mem_req_s = MEM_REQ_IDLE;
    a_resp    = 1'b0;
    b_resp    = 1'b0;
    unique case (sel)
      SERVE_A: begin
        mem_req_s = req_a_s;
        a_resp    = mem_resp;
      end
      SERVE_B: begin
        mem_req_s = req_b_s;
        b_resp    = mem_resp;
      end
      default: mem_req_s = MEM_REQ_IDLE;
    endcase
  end

  assign mem_read        = mem_req_s.read;
  assign mem_write       = mem_req_s.write;
  assign mem_byte_enable = mem_req_s.wmask;
  assign mem_address     = mem_req_s.address;
  assign mem_wdata       = mem_req_s.wdata;

  assign a_rdata = mem_rdata;
  assign b_rdata = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_lc3b_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lc3b_mem_arbiter : scoreboard bench with a word memory and two clients
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_lc3b_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_read = 0, a_write = 0, b_read = 0, b_write = 0;
  logic [1:0]  a_wmask = 0, b_wmask = 0;
  logic [15:0] a_address = 0, a_wdata = 0, b_address = 0, b_wdata = 0;
  logic        a_resp, b_resp, mem_read, mem_write, busy;
  logic [15:0] a_rdata, b_rdata, mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable, grant;
  logic        mem_resp_m = 0, force_resp = 0, mem_resp;
  logic [15:0] mem_rdata = 0;
  logic        fp_a_resp, fp_b_resp, fp_mem_read, fp_mem_write, fp_busy;
  logic [15:0] fp_a_rdata, fp_b_rdata, fp_mem_address, fp_mem_wdata;
  logic [1:0]  fp_mem_byte_enable, fp_grant;

  assign mem_resp = mem_resp_m | force_resp;
  always #5 clk = ~clk;

  lc3b_mem_arbiter #(.RR_MODE(1), .ADDR_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_read(a_read), .a_write(a_write), .a_wmask(a_wmask), .a_address(a_address),
    .a_wdata(a_wdata), .a_resp(a_resp), .a_rdata(a_rdata),
    .b_read(b_read), .b_write(b_write), .b_wmask(b_wmask), .b_address(b_address),
    .b_wdata(b_wdata), .b_resp(b_resp), .b_rdata(b_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_resp(mem_resp),
    .mem_rdata(mem_rdata), .grant(grant), .busy(busy));

  // Fixed-priority instance with both clients requesting forever.
  lc3b_mem_arbiter #(.RR_MODE(0), .ADDR_W(16)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .a_read(1'b0), .a_write(1'b1), .a_wmask(2'b11), .a_address(16'h3000),
    .a_wdata(16'hBEEF), .a_resp(fp_a_resp), .a_rdata(fp_a_rdata),
    .b_read(1'b1), .b_write(1'b0), .b_wmask(2'b11), .b_address(16'h8000),
    .b_wdata(16'h0000), .b_resp(fp_b_resp), .b_rdata(fp_b_rdata),
    .mem_read(fp_mem_read), .mem_write(fp_mem_write), .mem_byte_enable(fp_mem_byte_enable),
    .mem_address(fp_mem_address), .mem_wdata(fp_mem_wdata),
    .mem_resp(fp_mem_read | fp_mem_write), .mem_rdata(16'h0000),
    .grant(fp_grant), .busy(fp_busy));

  typedef struct { bit rd; logic [15:0] data; } exp_t;
  exp_t        exp_a[$], exp_b[$];
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] mem_arr [logic [15:0]];
  int          checks = 0, failures = 0;
  int          lat_fix = 0;
  bit          spur_en = 0, mon_en = 0;
  int          fp_a_cnt = 0, fp_b_cnt = 0, fp_a_g = 0;

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                        input logic [1:0] m);
    return {m[1] ? n[15:8] : o[15:8], m[0] ? n[7:0] : o[7:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Memory: random (or fixed) latency, occasional spurious resp while idle.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        mem_resp_m = 0; mem_rdata = 0; cnt = 0;
      end else if (mem_resp_m) begin
        mem_resp_m = 0; mem_rdata = 0;
      end else if (mem_read || mem_write) begin
        if (cnt == 0) cnt = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
        cnt--;
        if (cnt == 0) begin
          mem_resp_m = 1;
          mem_rdata = mem_arr.exists(mem_address) ? mem_arr[mem_address] : 16'h0;
          if (mem_write) mem_arr[mem_address] = merge(mem_rdata, mem_wdata, mem_byte_enable);
        end
      end else if (spur_en && $urandom_range(0, 11) == 0) begin
        mem_resp_m = 1;
      end
    end
  end

  task automatic issue(input bit pb, input bit rd, input logic [15:0] addr,
                       input logic [15:0] wd, input logic [1:0] m, output time t);
    exp_t        e;
    logic [15:0] old;
    bit          got = 0;
    @(posedge clk); #1;
    old = ref_mem.exists(addr) ? ref_mem[addr] : 16'h0;
    e.rd = rd; e.data = old;
    if (!rd) ref_mem[addr] = merge(old, wd, m);
    if (pb) begin
      b_read = rd; b_write = !rd; b_wmask = rd ? 2'b11 : m; b_address = addr; b_wdata = wd;
      exp_b.push_back(e);
    end else begin
      a_read = rd; a_write = !rd; a_wmask = rd ? 2'b11 : m; a_address = addr; a_wdata = wd;
      exp_a.push_back(e);
    end
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      got = pb ? b_resp : a_resp;
    end
    chk(pb ? "b_resp_timeout" : "a_resp_timeout", 64'(got), 64'd1);
    t = $time;
  endtask

  task automatic idle(input bit pb);
    @(posedge clk); #1;
    if (pb) begin b_read = 0; b_write = 0; b_wmask = 0; b_address = 0; b_wdata = 0; end
    else    begin a_read = 0; a_write = 0; a_wmask = 0; a_address = 0; a_wdata = 0; end
  endtask

  task automatic client(input bit pb, input int n);
    time t;
    for (int i = 0; i < n; i++) begin
      logic [15:0] addr;
      addr = (pb ? 16'h8000 : 16'h3000) + 16'(2 * $urandom_range(0, 7));
      issue(pb, 1'($urandom_range(0, 1)), addr, 16'($urandom), 2'($urandom_range(1, 3)), t);
      if ($urandom_range(0, 2) != 0) begin
        idle(pb);
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
    end
    idle(pb);
  endtask

  task automatic pop_check(input bit pb);
    exp_t e;
    if ((pb ? exp_b.size() : exp_a.size()) == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_resp port=%0d got=resp exp=none", pb);
    end else begin
      e = pb ? exp_b.pop_front() : exp_a.pop_front();
      if (e.rd) chk(pb ? "b_rdata" : "a_rdata", pb ? b_rdata : a_rdata, e.data);
    end
  endtask

  // Monitor: grant follows "hold until mem_resp, one idle cycle, tie alternates".
  initial begin
    logic [1:0]  prv_g = 0, exp_g;
    logic        prv_resp = 0, prv_ra = 0, prv_rb = 0, last_w_b = 0;
    logic [50:0] exp_bus;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prv_g = 0; prv_resp = 0; prv_ra = 0; prv_rb = 0; last_w_b = 0;
      end else begin
        if (prv_g != 2'b00)       exp_g = prv_resp ? 2'b00 : prv_g;
        else if (prv_ra && prv_rb) exp_g = last_w_b ? 2'b01 : 2'b10;
        else if (prv_ra)          exp_g = 2'b01;
        else if (prv_rb)          exp_g = 2'b10;
        else                      exp_g = 2'b00;
        chk("grant", grant, exp_g);
        chk("busy", busy, 64'(exp_g != 2'b00));
        case (exp_g)
          2'b01:   exp_bus = {a_read, a_write, a_wmask, a_address, a_wdata};
          2'b10:   exp_bus = {b_read, b_write, b_wmask, b_address, b_wdata};
          default: exp_bus = '0;
        endcase
        chk("mem_bus", {mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata}, exp_bus);
        chk("a_resp", a_resp, 64'(exp_g == 2'b01 && mem_resp));
        chk("b_resp", b_resp, 64'(exp_g == 2'b10 && mem_resp));
        if ((a_read && a_write) || (b_read && b_write))
          $display("note: illegal read+write request from a client t=%0t", $time);
        if (a_resp) pop_check(0);
        if (b_resp) pop_check(1);
        if (exp_g == 2'b01 && mem_resp) last_w_b = 0;
        if (exp_g == 2'b10 && mem_resp) last_w_b = 1;
        prv_g = exp_g; prv_resp = mem_resp;
        prv_ra = a_read | a_write; prv_rb = b_read | b_write;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (fp_a_resp) fp_a_cnt++;
        if (fp_b_resp) fp_b_cnt++;
        if (fp_grant == 2'b01) fp_a_g++;
      end
    end
  end

  initial begin
    time ta, tb_t;
    mem_arr[16'h3000] = 16'h1234; ref_mem[16'h3000] = 16'h1234;
    mem_arr[16'h8000] = 16'h5A5A; ref_mem[16'h8000] = 16'h5A5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {grant, busy, mem_read, mem_write, a_resp, b_resp, mem_address}, 64'd0);
    @(posedge clk); #1 rst_n = 1; mon_en = 1;

    // Single A read, memory answers on the third granted cycle.
    lat_fix = 3;
    fork
      begin issue(0, 1, 16'h3000, 16'h0, 2'b11, ta); idle(0); end
      begin
        @(posedge clk); @(negedge clk); chk("t1_read_n", mem_read, 0);
        @(negedge clk); chk("t1_read_n1", {mem_read, grant}, {1'b1, 2'b01});
        @(negedge clk); chk("t1_resp_n2", a_resp, 0);
        @(negedge clk); chk("t1_resp_n3", {a_resp, b_resp, a_rdata}, {2'b10, 16'h1234});
      end
    join

    // Tie straight after reset: B first, then A's write.
    fork
      begin issue(0, 0, 16'h3002, 16'hBEEF, 2'b11, ta); idle(0); end
      begin issue(1, 1, 16'h8000, 16'h0, 2'b11, tb_t); idle(1); end
    join
    chk("tie_b_first", 64'(tb_t < ta), 64'd1);
    issue(0, 1, 16'h3002, 16'h0, 2'b11, ta);
    issue(0, 1, 16'h3000, 16'h0, 2'b11, ta);
    idle(0);

    lat_fix = 0; spur_en = 1;
    fork
      client(0, 40);
      client(1, 40);
    join
    spur_en = 0;
    repeat (6) @(posedge clk);
    chk("exp_a_drained", exp_a.size(), 0);
    chk("exp_b_drained", exp_b.size(), 0);
    chk("fp_a_resps", fp_a_cnt, 0);
    chk("fp_a_grants", fp_a_g, 0);
    chk("fp_b_serves", 64'(fp_b_cnt > 20), 64'd1);

    // Reset while A is being served.
    @(posedge clk); #1 mon_en = 0; lat_fix = 4;
    a_read = 1; a_address = 16'h3010; a_wmask = 2'b11;
    begin
      bit seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = (grant == 2'b01); end
      chk("rst_grant_seen", 64'(seen), 64'd1);
    end
    rst_n = 0; #1;
    chk("rst_async_outs", {grant, busy, mem_read, mem_write, mem_byte_enable,
                           mem_address, mem_wdata, a_resp, b_resp}, 64'd0);
    @(posedge clk); #1 a_read = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1 force_resp = 1;
    @(negedge clk);
    chk("late_resp", {a_resp, b_resp, grant, busy}, 64'd0);
    @(posedge clk); #1 force_resp = 0;
    @(negedge clk);
    chk("after_late", {grant, busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/lc3b_mem_arbiter.md
Name: lc3b_mem_arbiter

Overview:
- Shares the single LC-3b memory port between two requesters.
- Port A is the instruction-fetch side; port B is the data load/store side.
- Sits between the CPU core (or core plus future DMA/debug client) and the memory model.
- A registered FSM grants one client at a time and holds the grant until mem_resp. Each client sees the standard mem_read/mem_write/mem_resp handshake.

Parameters:
- RR_MODE, 1: 1 = round-robin on tie; 0 = fixed priority, port B wins.
- ADDR_W, 16: address width; matches lc3b_word.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- a_read  in  1  client A read request
- a_write  in  1  client A write request
- a_wmask  in  2  client A byte enable
- a_address  in  16  client A address
- a_wdata  in  16  client A write data
- a_resp  out  1  client A completion pulse
- a_rdata  out  16  client A read data
- b_read, b_write, b_wmask, b_address, b_wdata, b_resp, b_rdata: same as port A, for client B
- mem_read  out  1  to memory
- mem_write  out  1  to memory
- mem_byte_enable  out  2  to memory
- mem_address  out  16  to memory
- mem_wdata  out  16  to memory
- mem_resp  in  1  memory completion
- mem_rdata  in  16  memory read data
- grant  out  2  one-hot current owner: 01 = A, 10 = B, 00 = none
- busy  out  1  high when state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low. Reset forces state IDLE, last_grant = A, and all outputs to 0 immediately.
- States: IDLE, SERVE_A, SERVE_B.
- Request definitions: req_a = a_read | a_write; req_b = b_read | b_write.
- IDLE, sampled at the clock edge:
  - Only req_a: go to SERVE_A.
  - Only req_b: go to SERVE_B.
  - Both, RR_MODE = 1: grant the port not equal to last_grant.
  - Both, RR_MODE = 0: go to SERVE_B.
  - Neither: stay in IDLE.
- SERVE_x:
  - Memory outputs are driven combinationally from client x's read/write/wmask/address/wdata.
  - x_resp = mem_resp; the other client's resp is forced to 0.
  - On mem_resp = 1: go to IDLE and set last_grant = x.
- Memory outputs in IDLE: mem_read = mem_write = 0, mem_byte_enable = 0, address and wdata = 0.
- Latency:
  - A request first asserted in cycle n appears on mem_* in cycle n+1.
  - After mem_resp in cycle m, the next grant is driven no earlier than cycle m+2.
  - This one-cycle IDLE gap guarantees mem_read/mem_write deassert between transactions.
- Read data: a_rdata = b_rdata = mem_rdata, broadcast. Data is valid only when the matching resp is high.
- Client rules:
  - A client holds its request and its fields stable until its resp.
  - If a client drops its request mid-grant, the arbiter still holds the grant and forwards the (now-zero) controls. It waits for mem_resp; no timeout.
- Read and write asserted together by one client is illegal. The arbiter forwards both unchanged; the bench flags it.
- mem_resp while in IDLE is ignored: no resp to any client, no state change.
- rst_n asserted mid-transaction: immediate return to IDLE, outputs 0, no resp pulse. The in-flight memory access is abandoned.
- grant and busy are decoded from the state register, so they are glitch-free.

Decomposition:
- Add to lc3b_types:
  - lc3b_arb_state enum {IDLE, SERVE_A, SERVE_B}.
  - lc3b_mem_req struct {read, write, wmask, address, wdata}, so each client port can be bundled.
- Natural sub-module: lc3b_arb_fsm. It holds the state register, last_grant, and next-state logic, and outputs the select. The top level is the muxing.

Test Plan:
- Single read A: a_read = 1, a_address = 0x3000; memory responds after 3 cycles with 0x1234. Required: mem_read rises 1 cycle after the request, a_resp pulses once with a_rdata = 0x1234, b_resp stays 0, grant = 01 then 00.
- Simultaneous A write and B read, RR_MODE = 1, after reset: B is granted first (last_grant = A). After B's mem_resp there is one IDLE cycle, then A is granted with mem_write = 1, mem_byte_enable = 11, mem_wdata = 0xBEEF.
- Same stimulus with RR_MODE = 0 and both clients continuously requesting: B is granted every time, A never.
- Back-to-back A reads with B idle: mem_read deasserts for exactly 1 cycle between transactions; two a_resp pulses are seen.
- Reset mid-grant: rst_n = 0 while in SERVE_A. All outputs go to 0 in the same cycle, before the next clk edge; after release, state is IDLE; a late mem_resp produces no client resp.
- Spurious mem_resp pulse in IDLE: no a_resp/b_resp, state and grant unchanged.
